// File: rtl/updown_counter4.sv
// 4-bit loadable up/down counter with terminal count for cascading.
// Define BCD_MODE_EN to restrict the count range to 0..9 (default 0..15).

module DFlipFlopAResetLow (
  input  logic c,
  input  logic re,
  input  logic d,
  output logic q
);

  always_ff @(posedge c or negedge re) begin
    if (!re) q <= 1'b0;
    else     q <= d;
  end

endmodule

module updown_counter4 (
  input  logic       c,
  input  logic       re,
  input  logic       en,
  input  logic       ld,
  input  logic       up,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic [3:0] q_,
  output logic       tc
);

`ifdef BCD_MODE_EN
  localparam logic [3:0] MAX = 4'd9;
`else
  localparam logic [3:0] MAX = 4'd15;
`endif

  logic [3:0] q_next;

  // Up from MAX or above wraps to 0, so out-of-range BCD loads recover on the next up-count.
  always_comb begin
    q_next = q;
    if (ld) begin
      q_next = d;
    end else if (en) begin
      if (up) q_next = (q >= MAX) ? 4'd0 : q + 4'd1;
      else    q_next = (q == 4'd0) ? MAX : q - 4'd1;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_bit
    DFlipFlopAResetLow u_ff (
      .c  (c),
      .re (re),
      .d  (q_next[i]),
      .q  (q[i])
    );
  end

  assign q_ = ~q;
  assign tc = en & ~ld & ((up & (q == MAX)) | (~up & (q == 4'd0)));

endmodule

// File: tb/tb_updown_counter4.sv
// Directed bench for updown_counter4; expected values are hand-computed.
// Define BCD_MODE_EN for both files to exercise the BCD range.

module tb_updown_counter4;

  logic       c = 1'b0;
  logic       re, en, ld, up;
  logic [3:0] d;
  logic [3:0] q, q_;
  logic       tc;
  int         passed = 0;
  int         total = 0;

  updown_counter4 dut (
    .c  (c),
    .re (re),
    .en (en),
    .ld (ld),
    .up (up),
    .d  (d),
    .q  (q),
    .q_ (q_),
    .tc (tc)
  );

  always #5 c = ~c;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk_q(input string tag, input logic [3:0] exp_q, input logic exp_tc);
    chk({tag, "_q"}, q, exp_q);
    chk({tag, "_qn"}, q_, ~exp_q);
    chk({tag, "_tc"}, {3'b000, tc}, {3'b000, exp_tc});
  endtask

  task automatic edge_step();
    @(posedge c);
    #1;
  endtask

  initial begin
    re = 1'b0; ld = 1'b1; en = 1'b0; up = 1'b1; d = 4'b0101;
    #1;
    chk_q("rst_t0", 4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      edge_step();
      chk_q("rst_edge", 4'b0000, 1'b0);
    end
    re = 1'b1;
    edge_step();
    chk_q("rst_release_load", 4'b0101, 1'b0);

`ifndef BCD_MODE_EN
    d = 4'b1101;
    edge_step();
    ld = 1'b0; en = 1'b1; up = 1'b1;
    #1;
    chk_q("upwrap_13", 4'b1101, 1'b0);
    edge_step();
    chk_q("upwrap_14", 4'b1110, 1'b0);
    edge_step();
    chk_q("upwrap_15", 4'b1111, 1'b1);
    edge_step();
    chk_q("upwrap_0", 4'b0000, 1'b0);
`endif

    ld = 1'b1; en = 1'b1; up = 1'b0; d = 4'b0001;
    #1;
    chk("load_tc_masked", {3'b000, tc}, 4'b0000);
    edge_step();
    ld = 1'b0;
    #1;
    chk_q("dnwrap_1", 4'b0001, 1'b0);
    edge_step();
    chk_q("dnwrap_0", 4'b0000, 1'b1);
    en = 1'b0;
    #1;
    chk_q("dn_tc_en0", 4'b0000, 1'b0);
    en = 1'b1;
    edge_step();
`ifdef BCD_MODE_EN
    chk_q("dnwrap_9", 4'b1001, 1'b0);
`else
    chk_q("dnwrap_15", 4'b1111, 1'b0);
`endif

    ld = 1'b1; d = 4'b0011;
    edge_step();
    up = 1'b1; d = 4'b1000;
    #1;
    chk_q("prio_before", 4'b0011, 1'b0);
    edge_step();
    chk_q("prio_load", 4'b1000, 1'b0);
    ld = 1'b0; en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      edge_step();
      chk_q("hold", 4'b1000, 1'b0);
    end

`ifdef BCD_MODE_EN
    ld = 1'b1; d = 4'b1100;
    edge_step();
    ld = 1'b0; en = 1'b1; up = 1'b1;
    #1;
    chk_q("bcd_load12_up", 4'b1100, 1'b0);
    edge_step();
    chk_q("bcd_12_up", 4'b0000, 1'b0);
    ld = 1'b1;
    edge_step();
    ld = 1'b0; up = 1'b0;
    #1;
    chk_q("bcd_load12_dn", 4'b1100, 1'b0);
    edge_step();
    chk_q("bcd_12_dn", 4'b1011, 1'b0);
    ld = 1'b1; d = 4'b0000;
    edge_step();
    ld = 1'b0; up = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk_q("bcd_count", 4'(i), (i == 9));
      edge_step();
    end
    chk_q("bcd_wrap", 4'b0000, 1'b0);
`endif

    ld = 1'b1; d = 4'b0101; en = 1'b1; up = 1'b1;
    edge_step();
    ld = 1'b0;
    edge_step();
    chk_q("mid_count", 4'b0110, 1'b0);
    #2 re = 1'b0;
    #1;
    chk_q("async_rst", 4'b0000, 1'b0);
    edge_step();
    chk_q("rst_held_edge", 4'b0000, 1'b0);
    #2 re = 1'b1;
    edge_step();
    chk_q("resume", 4'b0001, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1);
  end

endmodule
